// File: rtl/snake_pkg.sv
// snake_pkg: shared grid constants, spawn FSM states and cell-to-pixel mapping
package snake_pkg;
  localparam int GRID_W = 80;
  localparam int GRID_H = 60;
  localparam int CELL_PX = 10;
  typedef enum logic [2:0] {IDLE, PICK, QUERY, SCAN, COMMIT} state_t;
  function automatic logic [11:0] cell_px(input logic [6:0] c);
    return ({5'd0, c} << 3) + ({5'd0, c} << 1) + 12'(CELL_PX / 2);
  endfunction
endpackage

// File: rtl/snake_lfsr16.sv
// snake_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), held at SEED during reset
module snake_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  // shift toward the MSB with the tap parity entering bit 0
  always_ff @(posedge clk) q <= rst ? SEED : {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/fruit_spawn_ctrl.sv
// fruit_spawn_ctrl: picks a free grid cell for the next fruit via the occupancy port; define FRUIT_SCAN_FALLBACK_EN for the linear-scan fallback
module fruit_spawn_ctrl #(
  parameter int          GRID_W    = snake_pkg::GRID_W,
  parameter int          GRID_H    = snake_pkg::GRID_H,
  parameter int          MAX_TRIES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eat,
  output logic        occ_req,
  output logic [6:0]  occ_x,
  output logic [5:0]  occ_y,
  input  logic        occ_ack,
  input  logic        occ_hit,
  output logic [11:0] fruit_x,
  output logic [11:0] fruit_y,
  output logic        fruit_valid,
  output logic        busy,
  output logic        grid_full
);
  import snake_pkg::*;
  logic [15:0] lfsr;
  logic        eat_q;
  logic [7:0]  tries;
  logic [8:0]  tries_inc;
  logic [6:0]  cx;
  logic [5:0]  cy;
  logic        lfsr_unused;
  state_t      state;
  snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
  assign lfsr_unused = ^{lfsr[15], lfsr[8:7]};
  // fold raw LFSR bits into the grid and count the attempt about to be made
  always_comb begin
    cx = lfsr[6:0] >= 7'(GRID_W) ? lfsr[6:0] - 7'(GRID_W) : lfsr[6:0];
    cy = lfsr[14:9] >= 6'(GRID_H) ? lfsr[14:9] - 6'(GRID_H) : lfsr[14:9];
    tries_inc = {1'b0, tries} + 9'd1;
  end
`ifdef FRUIT_SCAN_FALLBACK_EN
  logic [12:0] scan_cnt;
  logic [6:0]  nx;
  logic [5:0]  ny;
  logic        in_scan;
  // raster successor of the queried cell; tries parks at MAX_TRIES during the scan
  always_comb begin
    nx = occ_x == 7'(GRID_W - 1) ? 7'd0 : occ_x + 7'd1;
    ny = occ_x != 7'(GRID_W - 1) ? occ_y : occ_y == 6'(GRID_H - 1) ? 6'd0 : occ_y + 6'd1;
    in_scan = tries == 8'(MAX_TRIES);
  end
`else
  assign grid_full = 1'b0;
`endif
  // respawn sequencer: edge detect, random pick, occupancy handshake, commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      eat_q       <= 1'b0;
      tries       <= '0;
      busy        <= 1'b0;
      fruit_valid <= 1'b1;
      occ_req     <= 1'b0;
      occ_x       <= '0;
      occ_y       <= '0;
      fruit_x     <= cell_px(7'(GRID_W / 2 - 1));
      fruit_y     <= cell_px(7'(GRID_H / 2 - 1));
`ifdef FRUIT_SCAN_FALLBACK_EN
      scan_cnt    <= '0;
      grid_full   <= 1'b0;
`endif
    end else begin
      eat_q <= eat;
      case (state)
        IDLE: if (eat && !eat_q) begin
          state       <= PICK;
          busy        <= 1'b1;
          fruit_valid <= 1'b0;
          tries       <= '0;
        end
        PICK: begin
          occ_x   <= cx;
          occ_y   <= cy;
          occ_req <= 1'b1;
          state   <= QUERY;
        end
        QUERY: if (occ_ack) begin
          occ_req <= 1'b0;
          if (!occ_hit) state <= COMMIT;
`ifdef FRUIT_SCAN_FALLBACK_EN
          else if (in_scan) begin
            if (scan_cnt == 13'(GRID_W * GRID_H)) begin
              grid_full   <= 1'b1;
              busy        <= 1'b0;
              fruit_valid <= 1'b1;
              state       <= IDLE;
            end else state <= SCAN;
          end
`endif
          else if (tries_inc < 9'(MAX_TRIES)) begin
            tries <= tries_inc[7:0];
            state <= PICK;
          end
`ifdef FRUIT_SCAN_FALLBACK_EN
          else begin
            tries    <= 8'(MAX_TRIES);
            scan_cnt <= '0;
            state    <= SCAN;
          end
`else
          else begin
            tries <= '0;
            state <= PICK;
          end
`endif
        end
`ifdef FRUIT_SCAN_FALLBACK_EN
        SCAN: begin
          occ_x    <= nx;
          occ_y    <= ny;
          scan_cnt <= scan_cnt + 13'd1;
          occ_req  <= 1'b1;
          state    <= QUERY;
        end
`endif
        COMMIT: begin
          fruit_x     <= cell_px(occ_x);
          fruit_y     <= cell_px({1'b0, occ_y});
          fruit_valid <= 1'b1;
          busy        <= 1'b0;
`ifdef FRUIT_SCAN_FALLBACK_EN
          grid_full   <= 1'b0;
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fruit_spawn_ctrl.sv
// tb_fruit_spawn_ctrl: randomized respawns against an occupancy stub and a spec-level placement model
module tb_fruit_spawn_ctrl;
  localparam int MAX_TRIES = 16;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef FRUIT_SCAN_FALLBACK_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, eat = 1'b0, occ_ack = 1'b0, occ_hit = 1'b0;
  logic occ_req, fruit_valid, busy, grid_full;
  logic [6:0] occ_x;
  logic [5:0] occ_y;
  logic [11:0] fruit_x, fruit_y;
  int total = 0, bad = 0;
  int mode = 0, hit_n = 0, dly = 0, qn = 0, qx = 0, qy = 0, free_x = -1, free_y = -1, wait_cnt = 0;
  int old_x = 0, old_y = 0;
  bit cur_hit = 1'b0, req_d = 1'b0;
  logic [15:0] m_cur, m_prev;

  fruit_spawn_ctrl #(.GRID_W(80), .GRID_H(60), .MAX_TRIES(MAX_TRIES), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .eat(eat), .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .fruit_x(fruit_x), .fruit_y(fruit_y),
    .fruit_valid(fruit_valid), .busy(busy), .grid_full(grid_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    int fb;
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return 16'(((int'(x) << 1) | fb) & 16'hFFFF);
  endfunction

  always @(posedge clk) begin
    m_prev <= m_cur;
    m_cur  <= rst ? SEED : lfsr_next(m_cur);
  end

  // occupancy stub: checks each query address, answers per mode, adds ack noise while idle
  always @(negedge clk) begin : stub
    int ex, ey;
    if (occ_req === 1'b1 && !req_d) begin
      qn++;
      if (SCAN_EN && qn > MAX_TRIES) begin
        ex = (qx + 1) % 80;
        ey = (qx == 79) ? (qy + 1) % 60 : qy;
      end else begin
        ex = int'(m_prev[6:0]);
        if (ex >= 80) ex -= 80;
        ey = int'(m_prev[14:9]);
        if (ey >= 60) ey -= 60;
      end
      chk("query_x", occ_x, ex);
      chk("query_y", occ_y, ey);
      qx = occ_x;
      qy = occ_y;
      case (mode)
        0: begin cur_hit = 1'b0; wait_cnt = 0; end
        1: begin cur_hit = qn <= hit_n; wait_cnt = (qn <= hit_n) ? dly : 0; end
        2: begin cur_hit = !(qx == 79 && qy == 59); wait_cnt = $urandom_range(0, 1); end
        3: begin cur_hit = 1'b1; wait_cnt = 0; end
        default: begin cur_hit = ($urandom % 3) != 0; wait_cnt = $urandom_range(0, 3); end
      endcase
    end else if (occ_req === 1'b1) begin
      chk("stable_x", occ_x, qx);
      chk("stable_y", occ_y, qy);
    end
    if (occ_req === 1'b1) begin
      occ_ack = wait_cnt == 0;
      occ_hit = occ_ack ? cur_hit : $urandom_range(0, 1) != 0;
      if (occ_ack && !cur_hit) begin free_x = qx; free_y = qy; end
      if (wait_cnt > 0) wait_cnt--;
    end else begin
      occ_ack = ($urandom % 4) == 0;
      occ_hit = $urandom_range(0, 1) != 0;
    end
    req_d = occ_req === 1'b1;
  end

  task automatic do_respawn(input bit hold, input bit glitch, input bit commit, input int budget);
    int n = 0;
    eat = 1'b0;
    @(negedge clk);
    qn = 0; free_x = -1; free_y = -1; old_x = fruit_x; old_y = fruit_y;
    eat = 1'b1;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_valid", fruit_valid, 0);
    eat = hold;
    while (busy !== 1'b0 && n < budget) begin
      if (glitch) eat = $urandom_range(0, 1) != 0;
      @(negedge clk);
      n++;
    end
    if (glitch) eat = 1'b0;
    chk("idle_in_budget", n < budget, 1);
    chk("valid_after", fruit_valid, 1);
    if (commit) begin
      chk("fruit_x", fruit_x, 10 * free_x + 5);
      chk("fruit_y", fruit_y, 10 * free_y + 5);
      chk("x_range", fruit_x >= 5 && fruit_x <= 795 && fruit_x % 10 == 5, 1);
      chk("y_range", fruit_y >= 5 && fruit_y <= 595 && fruit_y % 10 == 5, 1);
      chk("gfull_clear", grid_full, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fx"}, fruit_x, 395);
    chk({tag, "_fy"}, fruit_y, 295);
    chk({tag, "_valid"}, fruit_valid, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, occ_req, 0);
    chk({tag, "_ox"}, occ_x, 0);
    chk({tag, "_oy"}, occ_y, 0);
    chk({tag, "_gfull"}, grid_full, 0);
  endtask

  initial begin
    int n, q0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("released");
    // cycle-exact respawn with a same-cycle free answer
    mode = 0;
    eat = 1'b0;
    @(negedge clk);
    qn = 0; free_x = -1; free_y = -1;
    eat = 1'b1;
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_valid", fruit_valid, 0);
    chk("t1_req", occ_req, 0);
    eat = 1'b0;
    @(negedge clk);
    chk("t2_req", occ_req, 1);
    chk("t2_fx", fruit_x, 395);
    @(negedge clk);
    chk("t3_req", occ_req, 0);
    chk("t3_valid", fruit_valid, 0);
    chk("t3_busy", busy, 1);
    @(negedge clk);
    chk("t4_valid", fruit_valid, 1);
    chk("t4_busy", busy, 0);
    chk("t4_fx", fruit_x, 10 * free_x + 5);
    chk("t4_fy", fruit_y, 10 * free_y + 5);
    chk("t4_queries", qn, 1);
    // three occupied answers, each acked two cycles late
    mode = 1; hit_n = 3; dly = 2;
    do_respawn(1'b0, 1'b0, 1'b1, 200);
    chk("hit3_queries", qn, 4);
    // more misses than MAX_TRIES
    mode = 1; hit_n = 20; dly = 0;
    do_respawn(1'b0, 1'b0, 1'b1, 500);
    chk("hit20_queries", qn, 21);
    // eat held high through a respawn must not retrigger
    mode = 4;
    do_respawn(1'b1, 1'b0, 1'b1, 2000);
    q0 = qn;
    repeat (6) begin
      @(negedge clk);
      chk("held_idle", busy, 0);
    end
    chk("held_queries", qn, q0);
    eat = 1'b0;
    // random occupancy, ack delays and eat glitches while busy
    for (int i = 0; i < 25; i++) begin
      mode = 4;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_respawn(1'b0, 1'b1, 1'b1, 3000);
    end
    // reset in the middle of a long query, with eat retoggled
    mode = 1; hit_n = 100; dly = 8;
    eat = 1'b0;
    @(negedge clk);
    qn = 0;
    eat = 1'b1;
    @(negedge clk);
    n = 0;
    while (occ_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rq_seen", n < 20, 1);
    eat = 1'b0;
    @(negedge clk);
    eat = 1'b1;
    @(negedge clk);
    chk("rq_hold", occ_req, 1);
    chk("rq_single", qn, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    eat = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    qn = 0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
    end
    mode = 0;
    do_respawn(1'b0, 1'b0, 1'b1, 100);
    chk("post_rst_queries", qn, 1);
`ifdef FRUIT_SCAN_FALLBACK_EN
    mode = 2;
    do_respawn(1'b0, 1'b0, 1'b1, 30000);
    chk("scan_fx", fruit_x, 795);
    chk("scan_fy", fruit_y, 595);
    mode = 3;
    do_respawn(1'b0, 1'b0, 1'b0, 30000);
    chk("full_flag", grid_full, 1);
    chk("full_queries", qn, 4816);
    chk("full_fx", fruit_x, old_x);
    chk("full_fy", fruit_y, old_y);
    chk("full_busy", busy, 0);
    mode = 0;
    do_respawn(1'b0, 1'b0, 1'b1, 100);
`else
    chk("gfull_tied", grid_full, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fruit_spawn_ctrl.md
# fruit_spawn_ctrl

Sequencer for fruit placement in the snake game. On each "fruit eaten" event it draws pseudo-random grid cells and checks each one against the snake-body occupancy store through a request/acknowledge port. It retries on collision and commits the first free cell as the new fruit position in pixel coordinates. It sits between the collision logic (input `eat`), the snake body store (occupancy port) and the VGA renderer (fruit position outputs).

## Interface
Parameters:
- `GRID_W`, 80: grid columns (10 px cells, 800 px wide)
- `GRID_H`, 60: grid rows (600 px high)
- `MAX_TRIES`, 16: random attempts before fallback, 1..255
- `LFSR_SEED`, 16'hACE1: LFSR value after reset, must be non-zero

Ports:
- `clk`  in  1: clock
- `rst`  in  1: reset, synchronous, active-high
- `eat`  in  1: level from collision logic; a 0→1 transition requests a respawn
- `occ_req`  out  1: occupancy query valid
- `occ_x`  out  7: queried column, 0..GRID_W-1
- `occ_y`  out  6: queried row, 0..GRID_H-1
- `occ_ack`  in  1: query answered this cycle
- `occ_hit`  in  1: cell occupied by snake; valid only when `occ_ack`=1
- `fruit_x`  out  12: fruit centre X in pixels
- `fruit_y`  out  12: fruit centre Y in pixels
- `fruit_valid`  out  1: fruit position stable and drawable
- `busy`  out  1: respawn in progress
- `grid_full`  out  1: no free cell exists (scan option only)

## Operation
- Reset values:
  - `fruit_x`=395, `fruit_y`=295 (cell 39,29), `fruit_valid`=1
  - `busy`=0, `occ_req`=0, `occ_x`=0, `occ_y`=0, `grid_full`=0
  - state IDLE, LFSR=`LFSR_SEED`, try counter=0, `eat_q`=0
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle, including during reset release; held at the seed only while `rst`=1.
- Candidate:
  - cx = lfsr[6:0], minus 80 if ≥80.
  - cy = lfsr[14:9], minus 60 if ≥60.
- Pixel mapping: p = cell*10+5, computed as (c<<3)+(c<<1)+5, zero-extended to 12 bits. Range: X 5..795, Y 5..595.
- Edge detect: `eat_q` registers `eat` every cycle. A respawn starts when `eat`=1 and `eat_q`=0.
- State machine:
  - IDLE: on edge → PICK; `busy`=1, `fruit_valid`=0, tries=0.
  - PICK: latch candidate into `occ_x`/`occ_y` → QUERY.
  - QUERY: `occ_req`=1 with stable `occ_x`/`occ_y` until `occ_ack`.
    - `occ_ack`&!`occ_hit` → COMMIT.
    - `occ_ack`&`occ_hit` → tries+1; if tries+1 < `MAX_TRIES` → PICK, else → SCAN (option) or PICK (no option).
  - SCAN: step the cell linearly (x+1; at x=GRID_W-1 wrap to 0 and y+1; at y=GRID_H-1 wrap to 0), then → QUERY. The scan counter counts visited cells. If 4800 cells are visited without a free cell: `grid_full`=1 → IDLE, position unchanged, `fruit_valid`=1.
  - COMMIT: load `fruit_x`/`fruit_y` from the mapped cell, `fruit_valid`=1, `busy`=0, `grid_full`=0 → IDLE.
- `eat` edges while not IDLE are ignored; they are not queued.
- `occ_ack` with `occ_req`=0 is ignored.
- `rst` in any state aborts immediately; all reset values apply on the next edge.

## Timing
- Edge detected at cycle t:
  - PICK at t+1
  - QUERY (`occ_req`=1) at t+2
  - With same-cycle ack and a free cell: COMMIT at t+3, new `fruit_x`/`fruit_y` visible at t+4.
- Each occupied random try adds 2 cycles plus ack wait.
- `fruit_valid` is low from t+1 through COMMIT inclusive.
- `occ_req` falls the cycle after ack.
- `occ_x`/`occ_y` must not change while `occ_req`=1.

## Configuration
- `FRUIT_SCAN_FALLBACK_EN` defined:
  - SCAN state and 13-bit scan counter are present.
  - A full grid produces `grid_full`.
  - Respawn is bounded at `MAX_TRIES` + 4800 queries.
- Undefined:
  - SCAN is absent.
  - After `MAX_TRIES` the try counter clears and random picks continue indefinitely.
  - `grid_full` is tied 0.

## Structure
- Package `snake_pkg`:
  - `GRID_W`/`GRID_H`/`CELL_PX` constants
  - state enum (IDLE, PICK, QUERY, SCAN, COMMIT)
  - cell-to-pixel function
- Sub-module `snake_lfsr16`: free-running LFSR with seed parameter and synchronous reset.

## Test plan
- Reset release → `fruit_x`=395, `fruit_y`=295, `fruit_valid`=1, `busy`=0.
- `eat` 0→1, stub acks same cycle with hit=0 → `occ_req` at t+2, new position at t+4 equal to the mapped LFSR candidate, within 5..795 / 5..595 and ≡5 mod 10.
- Stub returns hit=1 for the first 3 queries, with ack delayed 2 cycles each → 4 queries issued, address stable during each wait, commit on the 4th.
- `FRUIT_SCAN_FALLBACK_EN`, stub hits all cells except (79,59) → after 16 random tries the linear scan reaches (79,59); commit at 795,595.
- `FRUIT_SCAN_FALLBACK_EN`, stub always hits → `grid_full`=1 after 4816 queries, position unchanged.
- `rst` asserted during QUERY, and `eat` held high / retoggled while `busy` → reset values next cycle; no extra respawn from the held level.
